jtkcpu_stkseq: RTL and testbench

//  Stack push/pull sequencer for PSHS/PSHU/PULS/PULU, interrupt entry and RTI.
//  The ucode fires one start pulse with a register mask; this block walks the mask, one byte per bus access.
//  For each byte it drives the memory bus, selects and reloads registers, and updates the stack pointer.

---
 rtl/jtkcpu_stkseq.sv | 235 +++++++++++++++++++++++
 tb/tb_jtkcpu_stkseq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_stkseq.sv
// rtl/jtkcpu_stkseq.sv - stack push/pull sequencer: walks a register mask, one bus byte per access
module jtkcpu_stkseq #(
    parameter int AW   = 16,
    parameter int MSKW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            psh_start,
    input  logic            pul_start,
    input  logic [MSKW-1:0] mask,
    input  logic [AW-1:0]   sp_in,
    input  logic [15:0]     reg_rd,
    input  logic [7:0]      mem_din,
    input  logic            mem_busy,
    output logic            busy,
    output logic            done,
    output logic [2:0]      reg_sel,
    output logic            reg_we,
    output logic [15:0]     reg_wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_dout,
    output logic [AW-1:0]   sp_out,
    output logic            sp_we
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PICK = 3'd1;
    localparam logic [2:0] ST_XFER = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [MSKW-1:0] mask_q, mask_d;
    logic            dir_q, dir_d;
    logic            sel_vld_q, sel_vld_d;
    logic            byte_q, byte_d;
    logic [7:0]      hi_q, hi_d;
    logic [AW-1:0]   sp_q, sp_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      reg_sel_q, reg_sel_d;
    logic            reg_we_q, reg_we_d;
    logic [15:0]     reg_wdata_q, reg_wdata_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_dout_q, mem_dout_d;
    logic [AW-1:0]   sp_out_q, sp_out_d;
    logic            sp_we_q, sp_we_d;

    // Returns {found, index}: highest set bit when hi_first, else lowest.
    function automatic logic [3:0] pick_bit(input logic [MSKW-1:0] m, input logic hi_first);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < MSKW; i++) begin
            if (hi_first && m[i]) r = {1'b1, 3'(i)};
        end
        for (int i = MSKW - 1; i >= 0; i--) begin
            if (!hi_first && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] pk_start, pk_next;
    logic       last_byte;
    logic       go_pick;

    // The register is chosen on entry to PICK so reg_rd is already valid when the first byte is loaded.
    assign pk_start  = pick_bit(mask, psh_start);
    assign pk_next   = pick_bit(mask_q, dir_q);
    assign last_byte = !reg_sel_q[2] || byte_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        dir_d       = dir_q;
        sel_vld_d   = sel_vld_q;
        byte_d      = byte_q;
        hi_d        = hi_q;
        sp_d        = sp_q;
        done_d      = done_q;
        reg_sel_d   = reg_sel_q;
        reg_we_d    = reg_we_q;
        reg_wdata_d = reg_wdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        sp_out_d    = sp_out_q;
        sp_we_d     = sp_we_q;
        go_pick     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (psh_start || pul_start) begin
                    dir_d     = psh_start;
                    sp_d      = sp_in;
                    sel_vld_d = pk_start[3];
                    mask_d    = mask;
                    if (pk_start[3]) begin
                        reg_sel_d = pk_start[2:0];
                        mask_d    = mask & ~(MSKW'(1) << pk_start[2:0]);
                    end
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (!sel_vld_q) begin
                    done_d   = 1'b1;
                    sp_we_d  = 1'b1;
                    sp_out_d = sp_q;
                    state_d  = ST_DONE;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = dir_q;
                    byte_d    = 1'b0;
                    if (dir_q) begin
                        sp_d       = sp_q - AW'(1);
                        mem_addr_d = sp_q - AW'(1);
                        mem_dout_d = reg_rd[7:0];
                    end else begin
                        mem_addr_d = sp_q;
                    end
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!mem_busy) begin
                    if (dir_q) begin
                        if (!last_byte) begin
                            sp_d       = sp_q - AW'(1);
                            mem_addr_d = sp_q - AW'(1);
                            mem_dout_d = reg_rd[15:8];
                            byte_d     = 1'b1;
                        end else begin
                            mem_req_d = 1'b0;
                            go_pick   = 1'b1;
                        end
                    end else begin
                        sp_d = sp_q + AW'(1);
                        if (!last_byte) begin
                            hi_d       = mem_din;
                            mem_addr_d = sp_q + AW'(1);
                            byte_d     = 1'b1;
                        end else begin
                            mem_req_d   = 1'b0;
                            reg_we_d    = 1'b1;
                            reg_wdata_d = reg_sel_q[2] ? {hi_q, mem_din} : {8'h00, mem_din};
                            state_d     = ST_WB;
                        end
                    end
                end
            end
            ST_WB: begin
                reg_we_d = 1'b0;
                go_pick  = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b0;
                sp_we_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_pick) begin
            state_d   = ST_PICK;
            sel_vld_d = pk_next[3];
            if (pk_next[3]) begin
                reg_sel_d = pk_next[2:0];
                mask_d    = mask_q & ~(MSKW'(1) << pk_next[2:0]);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            dir_q       <= 1'b0;
            sel_vld_q   <= 1'b0;
            byte_q      <= 1'b0;
            hi_q        <= '0;
            sp_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reg_sel_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            sp_out_q    <= '0;
            sp_we_q     <= 1'b0;
        end else if (cen) begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            dir_q       <= dir_d;
            sel_vld_q   <= sel_vld_d;
            byte_q      <= byte_d;
            hi_q        <= hi_d;
            sp_q        <= sp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reg_sel_q   <= reg_sel_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            sp_out_q    <= sp_out_d;
            sp_we_q     <= sp_we_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_sel   = reg_sel_q;
    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dout  = mem_dout_q;
    assign sp_out    = sp_out_q;
    assign sp_we     = sp_we_q;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// tb/tb_jtkcpu_stkseq.sv - directed table-driven bench for jtkcpu_stkseq
module tb_jtkcpu_stkseq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic        psh_start = 1'b0;
    logic        pul_start = 1'b0;
    logic [7:0]  mask = '0;
    logic [15:0] sp_in = '0;
    logic [15:0] reg_rd;
    logic [7:0]  mem_din;
    logic        mem_busy = 1'b0;
    logic        busy, done, reg_we, mem_req, mem_we, sp_we;
    logic [2:0]  reg_sel;
    logic [15:0] reg_wdata, mem_addr, sp_out;
    logic [7:0]  mem_dout;

    jtkcpu_stkseq #(.AW(16), .MSKW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .psh_start(psh_start), .pul_start(pul_start), .mask(mask), .sp_in(sp_in),
        .reg_rd(reg_rd), .mem_din(mem_din), .mem_busy(mem_busy),
        .busy(busy), .done(done), .reg_sel(reg_sel), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .sp_out(sp_out), .sp_we(sp_we)
    );

    always #5 clk = ~clk;

    // Register file: CC, A, B, DP, X, Y, U, PC
    logic [15:0] gold [8];
    assign gold[0] = 16'h005A;
    assign gold[1] = 16'h0011;
    assign gold[2] = 16'h0022;
    assign gold[3] = 16'h0033;
    assign gold[4] = 16'hBEEF;
    assign gold[5] = 16'h5566;
    assign gold[6] = 16'h7788;
    assign gold[7] = 16'h1234;

    logic [7:0]  mem [0:65535];
    int          acc_total = 0;
    logic [2:0]  wsel [$];
    logic [15:0] wdat [$];

    assign reg_rd  = gold[reg_sel];
    assign mem_din = mem[mem_addr];

    always @(posedge clk) begin
        if (rst_n && cen) begin
            if (mem_req && !mem_busy) begin
                acc_total++;
                if (mem_we) mem[mem_addr] <= mem_dout;
            end
            if (reg_we) begin
                wsel.push_back(reg_sel);
                wdat.push_back(reg_wdata);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        psh;
        logic        pul;
        logic [7:0]  m;
        logic [15:0] sp;
        int          cyc;
        logic [15:0] spo;
        int          nbytes;
    } vec_t;

    // Start at cycle 0, then step one negedge per cycle until done, driving the
    // mem_busy / cen-low / stray pul_start windows and checking bus stability in [k_lo,k_hi].
    task automatic seq(input vec_t v, input int b_lo, input int b_hi, input int c_lo, input int c_hi,
                       input int i_lo, input int i_hi, input int k_lo, input int k_hi,
                       input logic [15:0] k_addr, input logic [7:0] k_dout,
                       output int cyc, output int nacc, output int wbase);
        int acc0;
        @(negedge clk);
        psh_start = v.psh;
        pul_start = v.pul;
        mask      = v.m;
        sp_in     = v.sp;
        acc0      = acc_total;
        wbase     = wsel.size();
        cyc       = 0;
        @(negedge clk);
        psh_start = 1'b0;
        pul_start = 1'b0;
        cyc       = 1;
        while (!done && cyc < 200) begin
            if (cyc >= k_lo && cyc <= k_hi) begin
                chk($sformatf("hold_req_c%0d", cyc), mem_req, 1);
                chk($sformatf("hold_addr_c%0d", cyc), mem_addr, k_addr);
                chk($sformatf("hold_dout_c%0d", cyc), mem_dout, k_dout);
            end
            mem_busy  = (cyc >= b_lo && cyc <= b_hi);
            cen       = !(cyc >= c_lo && cyc <= c_hi);
            pul_start = (cyc >= i_lo && cyc <= i_hi);
            @(negedge clk);
            cyc++;
        end
        mem_busy  = 1'b0;
        cen       = 1'b1;
        pul_start = 1'b0;
        nacc      = acc_total - acc0;
    endtask

    vec_t tbl [9];
    vec_t v;
    int   cyc, nacc, wbase, k;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h81, 16'h1000,  7, 16'h0FFD,  3};
        tbl[1] = '{1'b0, 1'b1, 8'h81, 16'h0FFD,  9, 16'h1000,  3};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 16'h4321,  2, 16'h4321,  0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 16'h8000,  2, 16'h8000,  0};
        tbl[4] = '{1'b1, 1'b0, 8'hFF, 16'h2000, 22, 16'h1FF4, 12};
        tbl[5] = '{1'b0, 1'b1, 8'hFF, 16'h1FF4, 30, 16'h2000, 12};
        tbl[6] = '{1'b1, 1'b0, 8'h10, 16'h0001,  5, 16'hFFFF,  2};
        tbl[7] = '{1'b0, 1'b1, 8'h10, 16'hFFFF,  6, 16'h0001,  2};
        tbl[8] = '{1'b1, 1'b1, 8'h06, 16'h0100,  6, 16'h00FE,  2};

        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, done, reg_sel, reg_we, mem_req, mem_we, sp_we}, 0);
        chk("reset_data", {reg_wdata, mem_addr, mem_dout, sp_out}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            seq(tbl[i], 0, -1, 0, -1, 0, -1, 0, -1, 16'h0, 8'h0, cyc, nacc, wbase);
            chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
            chk($sformatf("v%0d_sp_out", i), sp_out, tbl[i].spo);
            chk($sformatf("v%0d_sp_we", i), sp_we, 1);
            chk($sformatf("v%0d_bytes", i), nacc, tbl[i].nbytes);
            @(negedge clk);
            chk($sformatf("v%0d_pulse_end", i), {done, sp_we, busy}, 0);
            if (tbl[i].pul && !tbl[i].psh) begin
                chk($sformatf("v%0d_we_count", i), wsel.size() - wbase, $countones(tbl[i].m));
                k = wbase;
                for (int b = 0; b < 8; b++) begin
                    if (tbl[i].m[b] && k < wsel.size()) begin
                        chk($sformatf("v%0d_sel_%0d", i, b), wsel[k], b);
                        chk($sformatf("v%0d_wdata_%0d", i, b), wdat[k], gold[b]);
                        k++;
                    end
                end
            end else begin
                chk($sformatf("v%0d_we_count", i), wsel.size() - wbase, 0);
            end
        end

        chk("mem_0FFF", mem[16'h0FFF], 8'h34);
        chk("mem_0FFE", mem[16'h0FFE], 8'h12);
        chk("mem_0FFD", mem[16'h0FFD], 8'h5A);
        chk("mem_0000", mem[16'h0000], 8'hEF);
        chk("mem_FFFF", mem[16'hFFFF], 8'hBE);
        chk("mem_00FF", mem[16'h00FF], 8'h22);
        chk("mem_00FE", mem[16'h00FE], 8'h11);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("full_lo_r%0d", 7 - r), mem[16'h1FFF - 16'(2 * r)], gold[7 - r][7:0]);
            chk($sformatf("full_hi_r%0d", 7 - r), mem[16'h1FFE - 16'(2 * r)], gold[7 - r][15:8]);
            chk($sformatf("full_b_r%0d", 3 - r), mem[16'h1FF7 - 16'(r)], gold[3 - r][7:0]);
        end

        // mem_busy for 3 cycles on the 2nd byte (PC high at 0x2FFE)
        v = '{1'b1, 1'b0, 8'h81, 16'h3000, 10, 16'h2FFD, 3};
        seq(v, 3, 5, 0, -1, 0, -1, 3, 6, 16'h2FFE, 8'h12, cyc, nacc, wbase);
        chk("stall_cycles", cyc, 10);
        chk("stall_sp_out", sp_out, 16'h2FFD);
        chk("stall_bytes", nacc, 3);
        chk("stall_mem", mem[16'h2FFE], 8'h12);

        // cen low for 3 cycles while the first byte of X is on the bus
        v = '{1'b1, 1'b0, 8'h10, 16'h5000, 8, 16'h4FFE, 2};
        seq(v, 0, -1, 2, 4, 0, -1, 2, 5, 16'h4FFF, 8'hEF, cyc, nacc, wbase);
        chk("cen_cycles", cyc, 8);
        chk("cen_sp_out", sp_out, 16'h4FFE);
        chk("cen_bytes", nacc, 2);

        // pul_start while busy is ignored
        v = '{1'b1, 1'b0, 8'h81, 16'h1000, 7, 16'h0FFD, 3};
        seq(v, 0, -1, 0, -1, 3, 4, 0, -1, 16'h0, 8'h0, cyc, nacc, wbase);
        chk("ign_cycles", cyc, 7);
        chk("ign_sp_out", sp_out, 16'h0FFD);
        @(negedge clk);
        chk("ign_idle1", busy, 0);
        @(negedge clk);
        chk("ign_idle2", {busy, mem_req}, 0);

        // reset pulse mid-XFER
        @(negedge clk);
        psh_start = 1'b1;
        mask      = 8'hFF;
        sp_in     = 16'h2000;
        @(negedge clk);
        psh_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {busy, done, reg_sel, reg_we, mem_req, mem_we, sp_we}, 0);
        chk("rst_mid_data", {reg_wdata, mem_addr, mem_dout, sp_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_after_%0d", c), {busy, done, reg_we, mem_req, sp_we}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
